// File: rtl/ibex_prefetch_buffer_multi_if.sv
// Instruction-side OBI-style bus between the prefetch buffer (master) and
// the instruction memory or icache (slave).
interface ibex_prefetch_buffer_multi_if;
   logic        instr_req_o;
   logic        instr_gnt_i;
   logic [31:0] instr_addr_o;
   logic [31:0] instr_rdata_i;
   logic        instr_err_i;
   logic        instr_rvalid_i;

   // Handshake: a request is issued in a cycle where instr_req_o & instr_gnt_i.
   // rvalid returns one response per grant, in order, and is never back-pressured.
   modport master (
      output instr_req_o, instr_addr_o,
      input  instr_gnt_i, instr_rdata_i, instr_err_i, instr_rvalid_i
   );

   modport slave (
      input  instr_req_o, instr_addr_o,
      output instr_gnt_i, instr_rdata_i, instr_err_i, instr_rvalid_i
   );
endinterface

// File: rtl/ibex_prefetch_buffer_multi.sv
// Word-aligned instruction prefetch buffer with several outstanding requests,
// branch-kill of in-flight responses, stop-on-error and a registered response FIFO.
module ibex_prefetch_buffer_multi #(
   parameter int unsigned NumOutstanding = 2,
   parameter int unsigned FifoDepth      = 3,
   parameter bit          ResetAll       = 1'b0
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic                                  req_i,
   input  logic                                  branch_i,
   input  logic [31:0]                           addr_i,
   input  logic                                  ready_i,
   output logic                                  valid_o,
   output logic [31:0]                           rdata_o,
   output logic [31:0]                           addr_o,
   output logic                                  err_o,
   ibex_prefetch_buffer_multi_if.master          bus,
   output logic [$clog2(NumOutstanding+1)-1:0]   outstanding_o,
   output logic                                  busy_o
);

   localparam int unsigned CntW = $clog2(NumOutstanding + 1);
   localparam int unsigned FcW  = $clog2(FifoDepth + 1);
   localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
   localparam int unsigned OccW = $clog2(FifoDepth + NumOutstanding + 1);

   logic [31:0]               fetch_addr_q;
   logic [CntW-1:0]           outst_q;
   logic                      err_stop_q;
   logic [31:0]               slot_addr_q [NumOutstanding];
   logic [31:0]               slot_addr_d [NumOutstanding];
   logic [NumOutstanding-1:0] slot_disc_q;
   logic [NumOutstanding-1:0] slot_disc_d;
   logic [31:0]               fifo_rdata_q [FifoDepth];
   logic [31:0]               fifo_addr_q  [FifoDepth];
   logic [FifoDepth-1:0]      fifo_err_q;
   logic [PtrW-1:0]           rd_ptr_q;
   logic [PtrW-1:0]           wr_ptr_q;
   logic [FcW-1:0]            fifo_cnt_q;

   logic [31:0]     branch_addr;
   logic [31:0]     req_addr;
   logic [OccW-1:0] occupancy;
   logic [CntW-1:0] slot_wr_idx;
   logic            credit_ok;
   logic            room_ok;
   logic            issue;
   logic            gnt_ok;
   logic            rsp_ok;
   logic            push;
   logic            pop;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(FifoDepth - 1)) ? '0 : p + 1'b1;
   endfunction

   assign branch_addr = addr_i & 32'hFFFF_FFFC;
   assign req_addr    = branch_i ? branch_addr : fetch_addr_q;
   assign credit_ok   = outst_q < CntW'(NumOutstanding);
   // Discarded in-flight slots still count against room, keeping the bound conservative.
   assign occupancy   = OccW'(fifo_cnt_q) + OccW'(outst_q);
   assign room_ok     = occupancy < OccW'(FifoDepth);
   assign issue       = credit_ok & (branch_i | (req_i & ~err_stop_q & room_ok));
   assign gnt_ok      = issue & bus.instr_gnt_i;
   assign rsp_ok      = bus.instr_rvalid_i & (outst_q != '0);
   // A response arriving in a branch cycle belongs to pre-branch fetch and is dropped.
   assign push        = rsp_ok & ~slot_disc_q[0] & ~branch_i;
   assign valid_o     = (fifo_cnt_q != '0) & ~branch_i;
   assign pop         = valid_o & ready_i;
   assign slot_wr_idx = outst_q - CntW'(rsp_ok);

   assign bus.instr_req_o  = issue;
   assign bus.instr_addr_o = req_addr;
   assign rdata_o          = valid_o ? fifo_rdata_q[rd_ptr_q] : '0;
   assign addr_o           = valid_o ? fifo_addr_q[rd_ptr_q]  : '0;
   assign err_o            = valid_o & fifo_err_q[rd_ptr_q];
   assign outstanding_o    = outst_q;
   assign busy_o           = issue | (outst_q != '0);

   // Slot 0 is always the oldest outstanding request; a response shifts the queue down.
   always_comb begin
      slot_addr_d = slot_addr_q;
      slot_disc_d = slot_disc_q;
      if (rsp_ok) begin
         for (int i = 0; i < int'(NumOutstanding) - 1; i++) begin
            slot_addr_d[i] = slot_addr_q[i+1];
            slot_disc_d[i] = slot_disc_q[i+1];
         end
      end
      if (branch_i) begin
         slot_disc_d = '1;
      end
      for (int i = 0; i < int'(NumOutstanding); i++) begin
         if (gnt_ok && (slot_wr_idx == CntW'(i))) begin
            slot_addr_d[i] = req_addr;
            slot_disc_d[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fetch_addr_q <= '0;
         outst_q      <= '0;
         err_stop_q   <= 1'b0;
         slot_disc_q  <= '0;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         fifo_cnt_q   <= '0;
      end else begin
         if (gnt_ok) begin
            fetch_addr_q <= req_addr + 32'd4;
         end else if (branch_i) begin
            fetch_addr_q <= branch_addr;
         end
         if (gnt_ok && !rsp_ok) begin
            outst_q <= outst_q + 1'b1;
         end else if (!gnt_ok && rsp_ok) begin
            outst_q <= outst_q - 1'b1;
         end
         slot_disc_q <= slot_disc_d;
         if (branch_i) begin
            err_stop_q <= 1'b0;
         end else if (push && bus.instr_err_i) begin
            err_stop_q <= 1'b1;
         end
         if (branch_i) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            fifo_cnt_q <= '0;
         end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (push && !pop) begin
               fifo_cnt_q <= fifo_cnt_q + 1'b1;
            end else if (!push && pop) begin
               fifo_cnt_q <= fifo_cnt_q - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (ResetAll && rst_i) begin
         for (int i = 0; i < int'(NumOutstanding); i++) begin
            slot_addr_q[i] <= '0;
         end
         for (int i = 0; i < int'(FifoDepth); i++) begin
            fifo_rdata_q[i] <= '0;
            fifo_addr_q[i]  <= '0;
         end
         fifo_err_q <= '0;
      end else begin
         slot_addr_q <= slot_addr_d;
         if (push) begin
            fifo_rdata_q[wr_ptr_q] <= bus.instr_rdata_i;
            fifo_addr_q[wr_ptr_q]  <= slot_addr_q[0];
            fifo_err_q[wr_ptr_q]   <= bus.instr_err_i;
         end
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         assert (!(bus.instr_rvalid_i && (outst_q == '0)))
            else $error("instr_rvalid_i with no outstanding request");
         assert (!(push && !pop && (fifo_cnt_q == FcW'(FifoDepth))))
            else $error("response FIFO overflow");
      end
   end
`endif

endmodule

// File: tb/tb_ibex_prefetch_buffer_multi.sv
// Directed bench for ibex_prefetch_buffer_multi: a small in-order bus responder
// returns rdata = ~addr; each scenario task checks hand-computed expectations.
module tb_ibex_prefetch_buffer_multi;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        req_i;
   logic        branch_i;
   logic [31:0] addr_i;
   logic        ready_i;
   logic        valid_o;
   logic [31:0] rdata_o;
   logic [31:0] addr_o;
   logic        err_o;
   logic [1:0]  outstanding_o;
   logic        busy_o;

   ibex_prefetch_buffer_multi_if bus_if ();

   ibex_prefetch_buffer_multi #(
      .NumOutstanding (2),
      .FifoDepth      (3),
      .ResetAll       (1'b0)
   ) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .req_i         (req_i),
      .branch_i      (branch_i),
      .addr_i        (addr_i),
      .ready_i       (ready_i),
      .valid_o       (valid_o),
      .rdata_o       (rdata_o),
      .addr_o        (addr_o),
      .err_o         (err_o),
      .bus           (bus_if),
      .outstanding_o (outstanding_o),
      .busy_o        (busy_o)
   );

   // ---------------- clock / reset ----------------
   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   // ---------------- scoreboard state ----------------
   int checks   = 0;
   int failures = 0;
   logic [31:0] pend_q[$];
   logic [31:0] gnt_log[$];
   logic [31:0] exp_q[$];
   logic [31:0] out_addr_q[$];

   logic        s_req, s_valid, s_err, s_busy, s_rv, s_pop;
   logic [31:0] s_addr, s_raddr, s_rdata;
   logic [1:0]  s_outst;

   // ---------------- driver tasks ----------------
   // One clock cycle: apply bus response, sample at negedge, update bus model at posedge.
   task automatic cyc(input logic g, input logic rv, input logic e);
      logic        taken;
      logic [31:0] ga;
      bus_if.instr_gnt_i    = g;
      bus_if.instr_rvalid_i = 1'b0;
      bus_if.instr_rdata_i  = 32'h0;
      if (rv && pend_q.size() > 0) begin
         bus_if.instr_rvalid_i = 1'b1;
         bus_if.instr_rdata_i  = ~pend_q[0];
      end
      bus_if.instr_err_i = e;
      @(negedge clk_i);
      s_req   = bus_if.instr_req_o;
      s_addr  = bus_if.instr_addr_o;
      s_valid = valid_o;
      s_raddr = addr_o;
      s_rdata = rdata_o;
      s_err   = err_o;
      s_outst = outstanding_o;
      s_busy  = busy_o;
      s_rv    = bus_if.instr_rvalid_i;
      s_pop   = valid_o & ready_i;
      if (s_pop) out_addr_q.push_back(addr_o);
      taken = s_req & g;
      ga    = s_addr;
      @(posedge clk_i);
      if (s_rv) void'(pend_q.pop_front());
      if (taken) begin
         pend_q.push_back(ga);
         gnt_log.push_back(ga);
      end
      #1;
      branch_i              = 1'b0;
      bus_if.instr_gnt_i    = 1'b0;
      bus_if.instr_rvalid_i = 1'b0;
      bus_if.instr_err_i    = 1'b0;
   endtask

   task automatic do_reset();
      rst_i = 1'b1; req_i = 1'b0; branch_i = 1'b0; addr_i = 32'h0; ready_i = 1'b0;
      pend_q.delete(); gnt_log.delete(); exp_q.delete(); out_addr_q.delete();
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      rst_i = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_i = 1'b1; req_i = 1'b0; branch_i = 1'b0; addr_i = 32'h0; ready_i = 1'b0;
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      checks++; if (s_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h exp=0", s_valid); end
      checks++; if (s_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%0h exp=0", s_req); end
      checks++; if (s_outst !== 2'd0) begin failures++; $display("FAIL reset_outst got=%0d exp=0", s_outst); end
      checks++; if (s_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0h exp=0", s_busy); end
      checks++; if (s_err !== 1'b0 || s_rdata !== 32'h0 || s_raddr !== 32'h0) begin
         failures++; $display("FAIL reset_head got err=%0h rdata=%h addr=%h exp all 0", s_err, s_rdata, s_raddr);
      end
      rst_i = 1'b0;
      cyc(1'b0, 1'b0, 1'b0);
      checks++; if (s_addr !== 32'h0) begin failures++; $display("FAIL reset_fetch_addr got=%h exp=00000000", s_addr); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      req_i = 1'b1; ready_i = 1'b1;
      branch_i = 1'b1; addr_i = 32'h100;
      cyc(1'b1, 1'b0, 1'b0);
      checks++; if (s_req !== 1'b1 || s_addr !== 32'h100) begin failures++; $display("FAIL b2b_first_req got req=%0h addr=%h exp 1/00000100", s_req, s_addr); end
      cyc(1'b1, 1'b1, 1'b0);
      checks++; if (s_valid !== 1'b0) begin failures++; $display("FAIL b2b_no_bypass got valid=%0h exp=0", s_valid); end
      cyc(1'b1, 1'b1, 1'b0);
      checks++; if (s_valid !== 1'b1 || s_raddr !== 32'h100 || s_rdata !== 32'hFFFF_FEFF) begin
         failures++; $display("FAIL b2b_first_word got v=%0h addr=%h data=%h exp 1/00000100/fffffeff", s_valid, s_raddr, s_rdata);
      end
      cyc(1'b0, 1'b1, 1'b0);
      checks++; if (s_raddr !== 32'h104) begin failures++; $display("FAIL b2b_second_word got=%h exp=00000104", s_raddr); end
      cyc(1'b0, 1'b0, 1'b0);
      checks++; if (s_raddr !== 32'h108) begin failures++; $display("FAIL b2b_third_word got=%h exp=00000108", s_raddr); end
      req_i = 1'b0;
      exp_q = '{32'h100, 32'h104, 32'h108};
      checks++; if (gnt_log.size() != 3) begin failures++; $display("FAIL b2b_grant_count got=%0d exp=3", gnt_log.size()); end
      for (int i = 0; i < exp_q.size() && i < gnt_log.size(); i++) begin
         checks++; if (gnt_log[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_grant_addr[%0d] got=%h exp=%h", i, gnt_log[i], exp_q[i]); end
      end
   endtask

   task automatic test_outstanding_limit();
      do_reset();
      req_i = 1'b1; ready_i = 1'b1;
      branch_i = 1'b1; addr_i = 32'h400;
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      checks++; if (s_req !== 1'b0 || s_outst !== 2'd2 || s_busy !== 1'b1) begin
         failures++; $display("FAIL limit_stall got req=%0h outst=%0d busy=%0h exp 0/2/1", s_req, s_outst, s_busy);
      end
      cyc(1'b1, 1'b0, 1'b0);
      checks++; if (gnt_log.size() != 2) begin failures++; $display("FAIL limit_grants got=%0d exp=2", gnt_log.size()); end
      cyc(1'b1, 1'b1, 1'b0);
      checks++; if (s_req !== 1'b0) begin failures++; $display("FAIL limit_rvalid_cycle_req got=%0h exp=0", s_req); end
      cyc(1'b1, 1'b0, 1'b0);
      checks++; if (s_req !== 1'b1 || s_addr !== 32'h408 || s_outst !== 2'd1) begin
         failures++; $display("FAIL limit_resume got req=%0h addr=%h outst=%0d exp 1/00000408/1", s_req, s_addr, s_outst);
      end
      checks++; if (s_valid !== 1'b1 || s_raddr !== 32'h400) begin failures++; $display("FAIL limit_word got v=%0h addr=%h exp 1/00000400", s_valid, s_raddr); end
      req_i = 1'b0;
   endtask

   task automatic test_branch_kill();
      do_reset();
      req_i = 1'b1; ready_i = 1'b1;
      branch_i = 1'b1; addr_i = 32'h500;
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      branch_i = 1'b1; addr_i = 32'h200;
      cyc(1'b0, 1'b0, 1'b0);
      checks++; if (s_req !== 1'b0 || s_valid !== 1'b0) begin failures++; $display("FAIL kill_branch_cycle got req=%0h v=%0h exp 0/0", s_req, s_valid); end
      cyc(1'b1, 1'b1, 1'b0);
      checks++; if (s_valid !== 1'b0) begin failures++; $display("FAIL kill_drop1 got v=%0h exp=0", s_valid); end
      cyc(1'b1, 1'b1, 1'b0);
      checks++; if (s_req !== 1'b1 || s_addr !== 32'h200 || s_valid !== 1'b0) begin
         failures++; $display("FAIL kill_refetch got req=%0h addr=%h v=%0h exp 1/00000200/0", s_req, s_addr, s_valid);
      end
      cyc(1'b0, 1'b1, 1'b0);
      checks++; if (s_valid !== 1'b0) begin failures++; $display("FAIL kill_drop2 got v=%0h exp=0", s_valid); end
      cyc(1'b0, 1'b0, 1'b0);
      checks++; if (s_valid !== 1'b1 || s_raddr !== 32'h200 || s_rdata !== 32'hFFFF_FDFF) begin
         failures++; $display("FAIL kill_target_word got v=%0h addr=%h data=%h exp 1/00000200/fffffdff", s_valid, s_raddr, s_rdata);
      end
      checks++; if (out_addr_q.size() != 1) begin failures++; $display("FAIL kill_words_delivered got=%0d exp=1", out_addr_q.size()); end
      req_i = 1'b0;
   endtask

   task automatic test_branch_flush();
      do_reset();
      req_i = 1'b1; ready_i = 1'b0;
      branch_i = 1'b1; addr_i = 32'h900;
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0);
      branch_i = 1'b1; addr_i = 32'hA00;
      cyc(1'b1, 1'b0, 1'b0);
      checks++; if (s_valid !== 1'b0 || s_req !== 1'b1 || s_addr !== 32'hA00) begin
         failures++; $display("FAIL flush_branch_cycle got v=%0h req=%0h addr=%h exp 0/1/00000a00", s_valid, s_req, s_addr);
      end
      ready_i = 1'b1;
      cyc(1'b0, 1'b1, 1'b0);
      checks++; if (s_valid !== 1'b0 || s_outst !== 2'd2) begin failures++; $display("FAIL flush_emptied got v=%0h outst=%0d exp 0/2", s_valid, s_outst); end
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      checks++; if (s_valid !== 1'b1 || s_raddr !== 32'hA00) begin failures++; $display("FAIL flush_target_word got v=%0h addr=%h exp 1/00000a00", s_valid, s_raddr); end
      req_i = 1'b0;
   endtask

   task automatic test_fifo_backpressure();
      int occ;
      do_reset();
      occ = 0;
      req_i = 1'b1; ready_i = 1'b0;
      branch_i = 1'b1; addr_i = 32'h600;
      cyc(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 7; i++) begin
         cyc(1'b1, 1'b1, 1'b0);
         checks++; if (int'(s_outst) + occ > 3) begin failures++; $display("FAIL bp_credit[%0d] got=%0d exp<=3", i, int'(s_outst) + occ); end
         occ = occ + int'(s_rv) - int'(s_pop);
      end
      checks++; if (s_req !== 1'b0 || gnt_log.size() != 3) begin
         failures++; $display("FAIL bp_stall got req=%0h grants=%0d exp 0/3", s_req, gnt_log.size());
      end
      ready_i = 1'b1;
      exp_q = '{32'h600, 32'h604, 32'h608};
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b0, 1'b0);
         checks++; if (s_valid !== 1'b1 || s_raddr !== exp_q[i] || s_rdata !== ~exp_q[i]) begin
            failures++; $display("FAIL bp_drain[%0d] got v=%0h addr=%h data=%h exp addr=%h", i, s_valid, s_raddr, s_rdata, exp_q[i]);
         end
      end
      req_i = 1'b0;
   endtask

   task automatic test_error_stop();
      do_reset();
      req_i = 1'b1; ready_i = 1'b0;
      branch_i = 1'b1; addr_i = 32'h300;
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 1'b1);
      checks++; if (s_req !== 1'b1 || s_addr !== 32'h308) begin failures++; $display("FAIL err_last_req got req=%0h addr=%h exp 1/00000308", s_req, s_addr); end
      cyc(1'b1, 1'b1, 1'b0);
      checks++; if (s_req !== 1'b0) begin failures++; $display("FAIL err_stop_req got=%0h exp=0", s_req); end
      cyc(1'b1, 1'b0, 1'b0);
      checks++; if (s_req !== 1'b0 || s_busy !== 1'b0) begin failures++; $display("FAIL err_idle got req=%0h busy=%0h exp 0/0", s_req, s_busy); end
      ready_i = 1'b1;
      cyc(1'b0, 1'b0, 1'b0);
      checks++; if (s_err !== 1'b0 || s_raddr !== 32'h300) begin failures++; $display("FAIL err_head0 got err=%0h addr=%h exp 0/00000300", s_err, s_raddr); end
      cyc(1'b0, 1'b0, 1'b0);
      checks++; if (s_valid !== 1'b1 || s_err !== 1'b1 || s_raddr !== 32'h304) begin
         failures++; $display("FAIL err_head1 got v=%0h err=%0h addr=%h exp 1/1/00000304", s_valid, s_err, s_raddr);
      end
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      checks++; if (s_req !== 1'b0 || s_valid !== 1'b0) begin failures++; $display("FAIL err_held got req=%0h v=%0h exp 0/0", s_req, s_valid); end
      branch_i = 1'b1; addr_i = 32'h700;
      cyc(1'b1, 1'b0, 1'b0);
      checks++; if (s_req !== 1'b1 || s_addr !== 32'h700) begin failures++; $display("FAIL err_restart got req=%0h addr=%h exp 1/00000700", s_req, s_addr); end
      cyc(1'b0, 1'b0, 1'b0);
      checks++; if (s_req !== 1'b1 || s_addr !== 32'h704) begin failures++; $display("FAIL err_cleared got req=%0h addr=%h exp 1/00000704", s_req, s_addr); end
      req_i = 1'b0;
   endtask

   task automatic test_wrap();
      do_reset();
      req_i = 1'b1; ready_i = 1'b1;
      branch_i = 1'b1; addr_i = 32'hFFFF_FFFB;
      cyc(1'b1, 1'b0, 1'b0);
      checks++; if (s_addr !== 32'hFFFF_FFF8) begin failures++; $display("FAIL wrap_align got=%h exp=fffffff8", s_addr); end
      cyc(1'b1, 1'b1, 1'b0);
      checks++; if (s_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_top got=%h exp=fffffffc", s_addr); end
      cyc(1'b1, 1'b1, 1'b0);
      checks++; if (s_addr !== 32'h0 || s_req !== 1'b1) begin failures++; $display("FAIL wrap_zero got req=%0h addr=%h exp 1/00000000", s_req, s_addr); end
      cyc(1'b0, 1'b1, 1'b0);
      checks++; if (s_valid !== 1'b1 || s_raddr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_word got v=%0h addr=%h exp 1/fffffffc", s_valid, s_raddr); end
      req_i = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      req_i = 1'b1; ready_i = 1'b0;
      branch_i = 1'b1; addr_i = 32'h800;
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 1'b0);
      checks++; if (s_valid !== 1'b1 || s_busy !== 1'b1) begin failures++; $display("FAIL rstmid_pre got v=%0h busy=%0h exp 1/1", s_valid, s_busy); end
      rst_i = 1'b1; req_i = 1'b0;
      cyc(1'b0, 1'b0, 1'b0);
      pend_q.delete();
      rst_i = 1'b0;
      cyc(1'b0, 1'b0, 1'b0);
      checks++; if (s_valid !== 1'b0 || s_outst !== 2'd0 || s_busy !== 1'b0) begin
         failures++; $display("FAIL rstmid_cleared got v=%0h outst=%0d busy=%0h exp 0/0/0", s_valid, s_outst, s_busy);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      rst_i = 1'b1; req_i = 1'b0; branch_i = 1'b0; addr_i = 32'h0; ready_i = 1'b0;
      bus_if.instr_gnt_i    = 1'b0;
      bus_if.instr_rvalid_i = 1'b0;
      bus_if.instr_rdata_i  = 32'h0;
      bus_if.instr_err_i    = 1'b0;
      @(posedge clk_i);
      #1;
      test_reset();
      test_back_to_back();
      test_outstanding_limit();
      test_branch_kill();
      test_branch_flush();
      test_fifo_backpressure();
      test_error_stop();
      test_wrap();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
